// File: rtl/serial_frame_tx.sv
// serial_frame_tx: MSB-first serial frame transmitter (0,1 start marker, data, stop=1); define PARITY_EN to insert an even-parity bit before stop
module serial_frame_tx #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              serial_out,
  output logic              busy,
  output logic              frame_done
);
  localparam int CW = $clog2(DATA_W);
`ifdef PARITY_EN
  typedef enum logic [2:0] {IDLE, START0, START1, DATA, PARITY, STOP} state_t;
  logic p;
`else
  typedef enum logic [2:0] {IDLE, START0, START1, DATA, STOP} state_t;
`endif
  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [CW-1:0]     cnt;
  logic              accept, last;
  always_comb begin
    in_ready = state == IDLE || state == STOP;
    accept   = in_valid && in_ready;
    last     = cnt == CW'(DATA_W - 1);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state      <= IDLE;
      serial_out <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      shreg      <= '0;
      cnt        <= '0;
`ifdef PARITY_EN
      p          <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE, STOP: begin
          state      <= accept ? START0 : IDLE;
          serial_out <= !accept;
          busy       <= accept;
          if (accept) begin
            shreg <= in_data;
            cnt   <= '0;
`ifdef PARITY_EN
            p     <= ^in_data;
`endif
          end
        end
        START0: begin
          state      <= START1;
          serial_out <= 1'b1;
        end
        START1: begin
          state      <= DATA;
          serial_out <= shreg[DATA_W-1];
        end
        // the line already shows shreg's MSB, so the next bit out is one below it
        DATA: begin
          shreg <= shreg << 1;
          cnt   <= cnt + 1'b1;
`ifdef PARITY_EN
          state      <= last ? PARITY : DATA;
          serial_out <= last ? p : shreg[DATA_W-2];
`else
          state      <= last ? STOP : DATA;
          serial_out <= last ? 1'b1 : shreg[DATA_W-2];
          frame_done <= last;
`endif
        end
`ifdef PARITY_EN
        PARITY: begin
          state      <= STOP;
          serial_out <= 1'b1;
          frame_done <= 1'b1;
        end
`endif
        default: begin
          state      <= IDLE;
          serial_out <= 1'b1;
          busy       <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx: scoreboard bench; expected line bits are built per frame from the frame format
module tb_serial_frame_tx;
  localparam int DATA_W = 8;
  typedef struct packed {logic line; logic busy; logic done;} ent_t;
  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic in_ready, serial_out, busy, frame_done;
  int vectors = 0, miscompares = 0, accepts = 0;
  int exp_rises = 0, act_rises = 0;
  logic exp_prev = 1'b1, act_prev = 1'b1, exp_ready = 1'b1;
  ent_t q[$];
  serial_frame_tx #(.DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .serial_out(serial_out), .busy(busy), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // reference frame: start marker 0,1 then payload MSB first, optional even parity, stop 1
  task automatic push_frame(input logic [DATA_W-1:0] w);
    q.push_back('{1'b0, 1'b1, 1'b0});
    q.push_back('{1'b1, 1'b1, 1'b0});
    for (int i = DATA_W - 1; i >= 0; i--) q.push_back('{w[i], 1'b1, 1'b0});
`ifdef PARITY_EN
    q.push_back('{^w, 1'b1, 1'b0});
`endif
    q.push_back('{1'b1, 1'b1, 1'b1});
  endtask
  always @(posedge clk)
    if (!reset && in_valid && exp_ready) begin
      push_frame(in_data);
      accepts++;
    end
  always @(negedge clk)
    if (reset) begin
      q.delete();
      exp_ready = 1'b1;
      exp_prev  = 1'b1;
      act_prev  = 1'b1;
    end else begin
      ent_t e;
      e = q.size() != 0 ? q.pop_front() : '{1'b1, 1'b0, 1'b0};
      check("serial_out", serial_out, e.line);
      check("busy", busy, e.busy);
      check("frame_done", frame_done, e.done);
      check("in_ready", in_ready, !e.busy || e.done);
      exp_ready = !e.busy || e.done;
      if (!exp_prev && e.line) exp_rises++;
      if (!act_prev && serial_out) act_rises++;
      exp_prev = e.line;
      act_prev = serial_out;
    end
  task automatic send(input logic [DATA_W-1:0] w);
    int n = accepts;
    int t = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (accepts == n && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (accepts == n) check("accept_timeout", 0, 1);
  endtask
  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    idle(5);
    send(8'hA5);
    idle(14);
    send(8'h80);
    send(8'h01);
    idle(14);
    send(8'h07);
    idle(14);
    send(8'h00);
    send(8'hFF);
    idle(15);
    send(8'hA5);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("reset_line", serial_out, 1);
    check("reset_busy", busy, 0);
    check("reset_done", frame_done, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    idle(2);
    send(8'h3C);
    for (int i = 0; i < 30; i++) begin
      int gap;
      send(DATA_W'($urandom));
      gap = $urandom_range(0, 3);
      if (gap != 0) idle(gap * $urandom_range(1, 6));
    end
    in_valid = 1'b0;
    for (int t = 0; t < 200 && q.size() != 0; t++) @(posedge clk);
    check("drain", q.size(), 0);
    idle(3);
    check("detector_pulses", act_rises, exp_rises);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
